// File: rtl/spart_tx_hex_interface.sv
// Renders a captured binary value as ASCII hex (MS nibble first, optional CR LF)
// and feeds the characters one at a time to the SPART transmitter via tbr/tx_wr.
module spart_tx_hex_interface #(
  parameter int NIBBLES      = 4,
  parameter bit SEND_NEWLINE = 1'b1,
  parameter bit UPPERCASE    = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NIBBLES-1:0]   value,
  input  logic                   value_valid,
  output logic                   ready,
  input  logic                   tbr,
  output logic                   tx_wr,
  output logic [7:0]             tx_data,
  output logic                   done,
  output logic [15:0]            chars_sent
);

  localparam int FRAME_LEN = NIBBLES + (SEND_NEWLINE ? 2 : 0);
  localparam int IDX_W     = $clog2(FRAME_LEN + 1);
  localparam int TBL_SIZE  = 1 << IDX_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WRITE,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [4*NIBBLES-1:0] value_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [7:0]           tx_data_reg;
  logic [15:0]          chars_sent_reg;
  logic [7:0]           char_table [TBL_SIZE];

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10)
      return 8'h30 + {4'h0, nib};
    else if (UPPERCASE)
      return 8'h37 + {4'h0, nib};
    else
      return 8'h57 + {4'h0, nib};
  endfunction

  // Table is padded to a power of two so idx_reg indexes it without width games.
  generate
    for (genvar gi = 0; gi < TBL_SIZE; gi++) begin : g_char
      if (gi < NIBBLES) begin : g_digit
        assign char_table[gi] = hex_char(value_reg[4*(NIBBLES-1-gi) +: 4]);
      end else if (SEND_NEWLINE && gi == NIBBLES) begin : g_cr
        assign char_table[gi] = 8'h0D;
      end else if (SEND_NEWLINE && gi == NIBBLES + 1) begin : g_lf
        assign char_table[gi] = 8'h0A;
      end else begin : g_pad
        assign char_table[gi] = 8'h00;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (value_valid) state_next = ST_WAIT;
      ST_WAIT:  if (tbr) state_next = ST_WRITE;
      ST_WRITE: state_next = ST_HOLD;
      // tbr is deliberately not looked at here: SPART needs a cycle to drop it.
      ST_HOLD:  state_next = (idx_reg == IDX_W'(FRAME_LEN - 1)) ? ST_DONE : ST_WAIT;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_reg      <= '0;
      idx_reg        <= '0;
      tx_data_reg    <= 8'h00;
      chars_sent_reg <= 16'h0000;
    end else begin
      if (state_reg == ST_IDLE && value_valid) begin
        value_reg <= value;
        idx_reg   <= '0;
      end
      if (state_reg == ST_WAIT && tbr)
        tx_data_reg <= char_table[idx_reg];
      if (state_reg == ST_HOLD)
        idx_reg <= idx_reg + IDX_W'(1);
      if (state_reg == ST_WRITE)
        chars_sent_reg <= chars_sent_reg + 16'd1;
    end
  end

  assign ready      = (state_reg == ST_IDLE);
  assign tx_wr      = (state_reg == ST_WRITE);
  assign done       = (state_reg == ST_DONE);
  assign tx_data    = tx_data_reg;
  assign chars_sent = chars_sent_reg;

endmodule
